// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between the I-cache (req0) and D-cache (req1)
// control units, with four-phase request/ack handshakes and a watchdog on the RAM acknowledge.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  not_reset,
  input  logic                  req0_avalid,
  input  logic                  req0_rnw,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_ack,
  input  logic                  req1_avalid,
  input  logic                  req1_rnw,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_ack,
  output logic                  ram_avalid,
  output logic                  ram_rnw,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  ram_ack,
  output logic                  bus_err,
  output logic                  grant
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic                    last_grant_reg, last_grant_next;
  logic                    grant_reg, grant_next;
  logic                    ram_avalid_reg, ram_avalid_next;
  logic                    ram_rnw_reg, ram_rnw_next;
  logic [ADDR_WIDTH-1:0]   ram_addr_reg, ram_addr_next;
  logic [DATA_WIDTH-1:0]   ram_wdata_reg, ram_wdata_next;
  logic [CNT_WIDTH-1:0]    count_reg, count_next;
  logic [1:0]              ack_reg, ack_next;
  logic                    bus_err_reg, bus_err_next;
  logic [DATA_WIDTH-1:0]   rdata_reg [2];
  logic [DATA_WIDTH-1:0]   rdata_next [2];

  // Per-requester views of the two handshake ports, indexed by requester number.
  logic [1:0]              req_avalid;
  logic [1:0]              req_rnw;
  logic [ADDR_WIDTH-1:0]   req_addr [2];
  logic [DATA_WIDTH-1:0]   req_wdata [2];
  logic                    sel;

  assign req_avalid   = {req1_avalid, req0_avalid};
  assign req_rnw      = {req1_rnw, req0_rnw};
  assign req_addr[0]  = req0_addr;
  assign req_addr[1]  = req1_addr;
  assign req_wdata[0] = req0_wdata;
  assign req_wdata[1] = req1_wdata;

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    ram_avalid_next = ram_avalid_reg;
    ram_rnw_next    = ram_rnw_reg;
    ram_addr_next   = ram_addr_reg;
    ram_wdata_next  = ram_wdata_reg;
    count_next      = count_reg;
    ack_next        = ack_reg;
    bus_err_next    = bus_err_reg;
    rdata_next[0]   = rdata_reg[0];
    rdata_next[1]   = rdata_reg[1];
    sel             = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|req_avalid) begin
          // A tie goes to whoever was not served last; otherwise the sole requester wins.
          sel             = (&req_avalid) ? ~last_grant_reg : req_avalid[1];
          ram_rnw_next    = req_rnw[sel];
          ram_addr_next   = req_addr[sel];
          ram_wdata_next  = req_wdata[sel];
          ram_avalid_next = 1'b1;
          grant_next      = sel;
          last_grant_next = sel;
          count_next      = '0;
          state_next      = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        count_next = count_reg + CNT_WIDTH'(1);
        if (ram_ack) begin
          ram_avalid_next = 1'b0;
          if (ram_rnw_reg) begin
            rdata_next[grant_reg] = ram_rdata;
          end
          ack_next[grant_reg] = 1'b1;
          bus_err_next        = 1'b0;
          state_next          = DONE;
        end else if (count_reg == CNT_LAST) begin
          ram_avalid_next       = 1'b0;
          rdata_next[grant_reg] = '0;
          ack_next[grant_reg]   = 1'b1;
          bus_err_next          = 1'b1;
          state_next            = DONE;
        end
      end

      DONE: begin
        if (!req_avalid[grant_reg]) begin
          ack_next     = '0;
          bus_err_next = 1'b0;
          state_next   = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      grant_reg      <= 1'b0;
      ram_avalid_reg <= 1'b0;
      ram_rnw_reg    <= 1'b1;
      ram_addr_reg   <= '0;
      ram_wdata_reg  <= '0;
      count_reg      <= '0;
      ack_reg        <= '0;
      bus_err_reg    <= 1'b0;
      rdata_reg[0]   <= '0;
      rdata_reg[1]   <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
      ram_avalid_reg <= ram_avalid_next;
      ram_rnw_reg    <= ram_rnw_next;
      ram_addr_reg   <= ram_addr_next;
      ram_wdata_reg  <= ram_wdata_next;
      count_reg      <= count_next;
      ack_reg        <= ack_next;
      bus_err_reg    <= bus_err_next;
      rdata_reg[0]   <= rdata_next[0];
      rdata_reg[1]   <= rdata_next[1];
    end
  end

  assign ram_avalid = ram_avalid_reg;
  assign ram_rnw    = ram_rnw_reg;
  assign ram_addr   = ram_addr_reg;
  assign ram_wdata  = ram_wdata_reg;
  assign req0_ack   = ack_reg[0];
  assign req1_ack   = ack_reg[1];
  assign req0_rdata = rdata_reg[0];
  assign req1_rdata = rdata_reg[1];
  assign bus_err    = bus_err_reg;
  assign grant      = grant_reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a transaction-level model of the arbiter checked every cycle,
// directed handshake scenarios, and literal expectations for the key results.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic not_reset = 1'b0;
  logic req0_avalid = 1'b0, req0_rnw = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic req1_avalid = 1'b0, req1_rnw = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic req0_ack, req1_ack;
  logic ram_avalid, ram_rnw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic ram_ack = 1'b0;
  logic bus_err, grant;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .not_reset(not_reset),
    .req0_avalid(req0_avalid), .req0_rnw(req0_rnw), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_rdata(req0_rdata), .req0_ack(req0_ack),
    .req1_avalid(req1_avalid), .req1_rnw(req1_rnw), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_rdata(req1_rdata), .req1_ack(req1_ack),
    .ram_avalid(ram_avalid), .ram_rnw(ram_rnw), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .bus_err(bus_err), .grant(grant)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic          e_ram_avalid, e_ram_rnw, e_bus_err, e_grant;
  logic [AW-1:0] e_ram_addr;
  logic [DW-1:0] e_ram_wdata;
  logic [1:0]    e_ack;
  logic [DW-1:0] e_rdata [2];
  int            m_last;
  int            gnt_log[$];
  int            rst_events = 0;
  int            m_seen = 0;
  bit            cmp_en = 1'b0;

  always @(negedge not_reset) rst_events++;

  task automatic m_reset();
    e_ram_avalid = 1'b0; e_ram_rnw = 1'b1; e_ram_addr = '0; e_ram_wdata = '0;
    e_ack = '0; e_bus_err = 1'b0; e_grant = 1'b0;
    e_rdata[0] = '0; e_rdata[1] = '0;
    m_last = 1;
  endtask

  task automatic m_killed(output bit k);
    k = (!not_reset) || (rst_events != m_seen);
    if (k) begin
      m_seen = rst_events;
      m_reset();
    end
  endtask

  function automatic logic req_valid(input int n);
    return (n == 1) ? req1_avalid : req0_avalid;
  endfunction

  // One loop iteration is one whole transaction: wait for a request, run the RAM access
  // until ack or watchdog expiry, then hold the completion until the owner lets go.
  initial begin : model
    int sel, age, status;
    bit k;
    m_reset();
    forever begin
      @(posedge clk);
      m_killed(k);
      if (k) continue;
      if (!(req0_avalid || req1_avalid)) continue;
      if (req0_avalid && req1_avalid) sel = 1 - m_last;
      else sel = req1_avalid ? 1 : 0;
      m_last = sel;
      gnt_log.push_back(sel);
      e_grant = sel[0];
      e_ram_avalid = 1'b1;
      e_ram_rnw   = (sel == 1) ? req1_rnw : req0_rnw;
      e_ram_addr  = (sel == 1) ? req1_addr : req0_addr;
      e_ram_wdata = (sel == 1) ? req1_wdata : req0_wdata;
      age = 0;
      status = 0;
      while (status == 0) begin
        @(posedge clk);
        m_killed(k);
        if (k) status = 2;
        else begin
          age++;
          if (ram_ack) begin
            if (e_ram_rnw) e_rdata[sel] = ram_rdata;
            e_bus_err = 1'b0;
            status = 1;
          end else if (age == TO) begin
            e_rdata[sel] = '0;
            e_bus_err = 1'b1;
            status = 1;
          end
          if (status == 1) begin
            e_ram_avalid = 1'b0;
            e_ack[sel] = 1'b1;
          end
        end
      end
      if (status == 2) continue;
      status = 0;
      while (status == 0) begin
        @(posedge clk);
        m_killed(k);
        if (k) status = 2;
        else if (!req_valid(sel)) begin
          e_ack = '0;
          e_bus_err = 1'b0;
          status = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && not_reset && rst_events == m_seen) begin
      chk("ram_avalid", ram_avalid, e_ram_avalid);
      chk("ram_rnw", ram_rnw, e_ram_rnw);
      chk("ram_addr", ram_addr, e_ram_addr);
      chk("ram_wdata", ram_wdata, e_ram_wdata);
      chk("req0_ack", req0_ack, e_ack[0]);
      chk("req1_ack", req1_ack, e_ack[1]);
      chk("req0_rdata", req0_rdata, e_rdata[0]);
      chk("req1_rdata", req1_rdata, e_rdata[1]);
      chk("bus_err", bus_err, e_bus_err);
      chk("grant", grant, e_grant);
      chk("ack_exclusive", req0_ack & req1_ack, 1'b0);
    end
  end

  // ---------------- RAM responder and port monitor ----------------
  bit            ack_en = 1'b1;
  int            ack_delay = 1;
  logic [DW-1:0] ack_data = '0;
  int            rcnt = 0;

  always @(negedge clk) begin
    if (ram_avalid && !ram_ack && ack_en) begin
      rcnt++;
      if (rcnt >= ack_delay) begin
        ram_ack = 1'b1;
        ram_rdata = ack_data;
      end
    end else begin
      ram_ack = 1'b0;
      rcnt = 0;
    end
  end

  int            obs_grant[$];
  int            obs_gap[$];
  logic [AW-1:0] obs_addr = '0;
  logic [DW-1:0] obs_wdata = '0;
  logic          obs_rnw = 1'b0;
  logic          prev_av = 1'b0;
  int            hi_run = 0, last_run = 0, lo_run = 0;

  always @(negedge clk) begin
    if (ram_avalid && !prev_av) begin
      obs_grant.push_back(int'(grant));
      obs_gap.push_back(lo_run);
      obs_addr = ram_addr; obs_wdata = ram_wdata; obs_rnw = ram_rnw;
      lo_run = 0;
    end
    if (ram_avalid) hi_run++;
    else begin
      if (hi_run != 0) last_run = hi_run;
      hi_run = 0;
      lo_run++;
    end
    prev_av = ram_avalid;
  end

  // ---------------- requester driver ----------------
  task automatic set_req(input int n, input logic v, input logic rnw, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    if (n == 1) begin
      req1_avalid = v; req1_rnw = rnw; req1_addr = a; req1_wdata = d;
    end else begin
      req0_avalid = v; req0_rnw = rnw; req0_addr = a; req0_wdata = d;
    end
  endtask

  function automatic logic get_ack(input int n);
    return (n == 1) ? req1_ack : req0_ack;
  endfunction

  // Called at a falling edge; raises the request at once and returns at the falling edge
  // where the ack has been seen low again.
  task automatic do_txn(input int n, input logic rnw, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output logic [DW-1:0] rdata, output logic err);
    bit seen;
    set_req(n, 1'b1, rnw, a, d);
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      seen = get_ack(n);
    end
    chk("ack_rise_wait", seen, 1'b1);
    rdata = (n == 1) ? req1_rdata : req0_rdata;
    err = bus_err;
    set_req(n, 1'b0, rnw, a, d);
    for (int t = 0; t < 200 && seen; t++) begin
      @(negedge clk);
      seen = get_ack(n);
    end
    chk("ack_fall_wait", seen, 1'b0);
    $display("txn req%0d %s addr=%02h wdata=%08h rdata=%08h bus_err=%0d",
             n, rnw ? "rd" : "wr", a, d, rdata, err);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [DW-1:0] rd0, rd1;
    logic er0, er1;
    int exp_seq[4] = '{0, 1, 0, 1};
    int cnt;

    repeat (2) @(negedge clk);
    chk("rst_ram_avalid", ram_avalid, 1'b0);
    chk("rst_ram_rnw", ram_rnw, 1'b1);
    chk("rst_ram_addr", ram_addr, '0);
    chk("rst_req0_ack", req0_ack, 1'b0);
    chk("rst_req1_ack", req1_ack, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_grant", grant, 1'b0);
    chk("rst_req0_rdata", req0_rdata, '0);
    #3 not_reset = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // Both requesters keep asking: grants must alternate starting with requester 0.
    ack_en = 1'b1; ack_delay = 2; ack_data = 32'hA5A5_0001;
    fork
      begin
        do_txn(0, 1'b1, 8'h01, 32'h0, rd0, er0);
        do_txn(0, 1'b0, 8'h02, 32'h1111_1111, rd0, er0);
      end
      begin
        do_txn(1, 1'b1, 8'h81, 32'h0, rd1, er1);
        do_txn(1, 1'b0, 8'h82, 32'h2222_2222, rd1, er1);
      end
    join
    chk("fair_count", obs_grant.size(), 4);
    for (int i = 0; i < 4 && i < obs_grant.size(); i++) begin
      chk("fair_dut_grant", obs_grant[i], exp_seq[i]);
      chk("fair_model_grant", gnt_log[i], exp_seq[i]);
    end
    for (int i = 1; i < 4 && i < obs_gap.size(); i++)
      chk("fair_idle_gap", obs_gap[i] >= 2, 1'b1);

    // Single read with a three-cycle RAM latency.
    ack_delay = 3; ack_data = 32'hDEADBEEF;
    do_txn(0, 1'b1, 8'h10, 32'h0, rd0, er0);
    chk("rd_rdata", rd0, 32'hDEADBEEF);
    chk("rd_bus_err", er0, 1'b0);
    chk("rd_addr", obs_addr, 8'h10);
    chk("rd_rnw", obs_rnw, 1'b1);
    chk("rd_grant", obs_grant[$], 0);
    chk("rd_avalid_cycles", last_run, 3);

    // Single write from the D-cache side.
    ack_delay = 2;
    do_txn(1, 1'b0, 8'h22, 32'h12345678, rd1, er1);
    chk("wr_rnw", obs_rnw, 1'b0);
    chk("wr_addr", obs_addr, 8'h22);
    chk("wr_wdata", obs_wdata, 32'h12345678);
    chk("wr_bus_err", er1, 1'b0);
    chk("wr_grant", obs_grant[$], 1);

    // Watchdog: no ack at all.
    ack_en = 1'b0;
    do_txn(0, 1'b1, 8'h33, 32'h0, rd0, er0);
    chk("to_bus_err", er0, 1'b1);
    chk("to_rdata", rd0, 32'h0);
    chk("to_avalid_cycles", last_run, TO);
    ack_en = 1'b1; ack_delay = 1; ack_data = 32'hCAFE0001;
    do_txn(0, 1'b1, 8'h34, 32'h0, rd0, er0);
    chk("after_to_bus_err", er0, 1'b0);
    chk("after_to_rdata", rd0, 32'hCAFE0001);
    chk("min_avalid_cycles", last_run, 1);

    // Ack lands on the same edge as the watchdog would fire.
    ack_delay = TO; ack_data = 32'h0BADF00D;
    do_txn(1, 1'b1, 8'h44, 32'h0, rd1, er1);
    chk("coll_bus_err", er1, 1'b0);
    chk("coll_rdata", rd1, 32'h0BADF00D);
    chk("coll_avalid_cycles", last_run, TO);

    // Requester drops avalid while the access is outstanding: one ack cycle only.
    ack_delay = 3; ack_data = 32'h5555AAAA;
    set_req(0, 1'b1, 1'b1, 8'h55, 32'h0);
    @(negedge clk);
    req0_avalid = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (req0_ack) cnt++;
    end
    chk("viol_ack_cycles", cnt, 1);
    chk("viol_rdata", req0_rdata, 32'h5555AAAA);

    // Reset in the middle of an access.
    ack_en = 1'b0;
    set_req(0, 1'b1, 1'b1, 8'h66, 32'h0);
    repeat (3) @(negedge clk);
    chk("mr_pre_avalid", ram_avalid, 1'b1);
    #2 not_reset = 1'b0;
    #1;
    chk("mr_ram_avalid", ram_avalid, 1'b0);
    chk("mr_req0_ack", req0_ack, 1'b0);
    chk("mr_req1_ack", req1_ack, 1'b0);
    chk("mr_req0_rdata", req0_rdata, 32'h0);
    req0_avalid = 1'b0;
    repeat (2) @(negedge clk);
    #3 not_reset = 1'b1;
    @(negedge clk);
    ack_en = 1'b1; ack_delay = 2; ack_data = 32'h77778888;
    do_txn(1, 1'b1, 8'h77, 32'h0, rd1, er1);
    chk("mr_after_grant", obs_grant[$], 1);
    chk("mr_after_rdata", rd1, 32'h77778888);
    chk("mr_after_bus_err", er1, 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Two-requester arbiter that shares the single main-memory (RAM) port between the instruction-cache and data-cache control units. Each cache issues a read or write miss/write-back request through a four-phase handshake. The arbiter grants one requester at a time in round-robin order, drives the RAM port, and returns read data. A watchdog aborts transactions whose RAM acknowledge never arrives.

Parameters:
ADDR_WIDTH, 8, width of RAM word address
DATA_WIDTH, 32, width of RAM data word
TIMEOUT_CYCLES, 64, max cycles in WAIT_ACK before abort (>=2)

Ports:
clk  input  1  clock, all state on rising edge
not_reset  input  1  asynchronous, active-low reset
req0_avalid  input  1  requester 0 (I-cache) request valid, held until req0_ack seen
req0_rnw  input  1  requester 0 read(1)/write(0)
req0_addr  input  ADDR_WIDTH  requester 0 address
req0_wdata  input  DATA_WIDTH  requester 0 write data
req0_rdata  output  DATA_WIDTH  requester 0 read data, valid while req0_ack=1
req0_ack  output  1  requester 0 completion, held until req0_avalid drops
req1_avalid, req1_rnw, req1_addr, req1_wdata, req1_rdata, req1_ack  same as requester 0, for D-cache
ram_avalid  output  1  RAM access enable
ram_rnw  output  1  RAM read(1)/write(0)
ram_addr  output  ADDR_WIDTH  RAM address
ram_wdata  output  DATA_WIDTH  RAM write data
ram_rdata  input  DATA_WIDTH  RAM read data, valid with ram_ack
ram_ack  input  1  RAM completion
bus_err  output  1  high with reqN_ack when the transaction timed out
grant  output  1  index of current/last granted requester

Behaviour:
- Reset (async, not_reset=0): state=IDLE; all outputs 0 except ram_rnw=1; last_grant=1, so requester 0 wins first tie; timeout counter=0; rdata registers=0.
- All outputs registered; no combinational path from inputs to outputs.
- States: IDLE, WAIT_ACK, DONE.
- IDLE: on an edge where any reqN_avalid=1, select a requester:
  - Only one requesting: select it.
  - Both requesting: select !last_grant.
  - Latch rnw/addr/wdata of the selected requester onto the ram_* outputs; ram_avalid<=1; grant<=sel; last_grant<=sel; counter<=0; go to WAIT_ACK.
  - ram_avalid rises 1 cycle after the request is sampled.
- WAIT_ACK: ram_addr, ram_wdata and ram_rnw stay stable; counter increments each cycle.
  - ram_ack=1: ram_avalid<=0; if read, latch ram_rdata into reqN_rdata; reqN_ack<=1; bus_err<=0; go to DONE.
  - counter==TIMEOUT_CYCLES-1 with no ack: ram_avalid<=0; reqN_rdata<=0; reqN_ack<=1; bus_err<=1; go to DONE.
  - ram_ack on the same edge as the timeout: ack wins, bus_err=0.
  - The other requester's avalid is ignored.
- DONE: hold reqN_ack, reqN_rdata and bus_err until the granted reqN_avalid=0 is sampled. Then reqN_ack<=0, bus_err<=0, go to IDLE.
- After DONE, IDLE lasts at least 1 cycle, so back-to-back grants are spaced by one idle cycle.
- Minimum transaction: request sampled at edge k, ram_avalid high k+1, ram_ack at edge k+1 gives reqN_ack high after k+2.
- The non-granted ack stays 0 at all times; the two acks are never high together.
- ram_ack outside WAIT_ACK is ignored.
- Requester deasserting avalid during WAIT_ACK is a protocol violation: the transaction still completes, and DONE exits on the next edge.
- Reset mid-transaction returns immediately to the reset values; ram_avalid drops asynchronously.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1.

Test Plan:
- Single read: req0 read addr 0x10, RAM acks 3 cycles later with 0xDEADBEEF -> ram_avalid/ram_rnw=1, ram_addr=0x10; req0_rdata=0xDEADBEEF, req0_ack=1, held until req0_avalid drops; req1_ack stays 0.
- Single write: req1 write addr 0x22 data 0x12345678 -> ram_rnw=0, ram_addr=0x22, ram_wdata=0x12345678 until ram_ack; req1_ack=1, bus_err=0.
- Simultaneous requests from reset, both held for 4 transactions -> grant sequence 0,1,0,1; each ram_avalid rise separated by at least 1 IDLE cycle.
- Timeout: TIMEOUT_CYCLES=8, req0 read, ram_ack never asserted -> ram_avalid high exactly 8 cycles; req0_ack=1, bus_err=1, req0_rdata=0; the next transaction has bus_err=0.
- Ack/timeout collision: ram_ack on the 8th WAIT_ACK cycle -> normal completion with bus_err=0.
- Reset mid-transaction: not_reset low during WAIT_ACK -> ram_avalid=0 and all acks=0 immediately; after release, a new req1 request is granted normally.
